// File: rtl/std_cache_ctrl.sv
// Per-port L1 D-cache controller: looks up tag/data through the arbiter, serves hits,
// and hands misses and bypass accesses to the miss handler while honouring MSHR conflicts.
module std_cache_ctrl #(
   parameter logic [63:0] CACHE_START_ADDR = 64'h8000_0000,
   parameter int          SET_ASSOC        = 4,
   parameter int          INDEX_WIDTH      = 12,
   parameter int          TAG_WIDTH        = 44,
   parameter int          CL_WIDTH         = 128
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             flush_i,
   input  logic                             bypass_i,
   output logic                             busy_o,
   input  logic [INDEX_WIDTH-1:0]           req_port_i_address_index,
   input  logic [TAG_WIDTH-1:0]             req_port_i_address_tag,
   input  logic [63:0]                      req_port_i_data_wdata,
   input  logic                             req_port_i_data_req,
   input  logic                             req_port_i_data_we,
   input  logic [7:0]                       req_port_i_data_be,
   input  logic [1:0]                       req_port_i_data_size,
   input  logic                             req_port_i_kill_req,
   input  logic                             req_port_i_tag_valid,
   output logic                             req_port_o_data_gnt,
   output logic                             req_port_o_data_rvalid,
   output logic [63:0]                      req_port_o_data_rdata,
   output logic [SET_ASSOC-1:0]             req_o,
   output logic [INDEX_WIDTH-1:0]           addr_o,
   input  logic                             gnt_i,
   input  logic [SET_ASSOC*CL_WIDTH-1:0]    data_i,
   output logic [TAG_WIDTH-1:0]             tag_o,
   output logic [TAG_WIDTH-1:0]             data_o_tag,
   output logic [CL_WIDTH-1:0]              data_o_data,
   output logic                             data_o_valid,
   output logic                             data_o_dirty,
   output logic                             we_o,
   output logic [SET_ASSOC-1:0]             be_o_tag,
   output logic [CL_WIDTH/8-1:0]            be_o_data,
   output logic [SET_ASSOC-1:0]             be_o_vldrty,
   input  logic [SET_ASSOC-1:0]             hit_way_i,
   output logic                             miss_req_o_valid,
   output logic [63:0]                      miss_req_o_addr,
   output logic [7:0]                       miss_req_o_be,
   output logic [1:0]                       miss_req_o_size,
   output logic                             miss_req_o_we,
   output logic [63:0]                      miss_req_o_wdata,
   output logic                             miss_req_o_bypass,
   input  logic                             miss_gnt_i,
   input  logic                             active_serving_i,
   input  logic [63:0]                      critical_word_i,
   input  logic                             critical_word_valid_i,
   input  logic                             bypass_gnt_i,
   input  logic                             bypass_valid_i,
   input  logic [63:0]                      bypass_data_i,
   output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mshr_addr_o,
   input  logic                             mshr_addr_matches_i,
   input  logic                             mshr_index_matches_i
);

   localparam int WORDS  = CL_WIDTH / 64;
   localparam int OFF_W  = $clog2(WORDS);
   localparam int PAD_W  = 64 - TAG_WIDTH - INDEX_WIDTH;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_TAG,
      WAIT_TAG_BYPASSED,
      STORE_REQ,
      WAIT_MSHR,
      WAIT_TAG_SAVED,
      WAIT_REFILL_GNT,
      WAIT_REFILL_VALID,
      WAIT_CRITICAL_WORD
   } state_t;

   state_t                 r_state, w_state_d;
   logic [INDEX_WIDTH-1:0] r_index, w_index_d;
   logic [TAG_WIDTH-1:0]   r_tag, w_tag_d;
   logic [7:0]             r_be, w_be_d;
   logic [1:0]             r_size, w_size_d;
   logic                   r_we, w_we_d;
   logic [63:0]            r_wdata, w_wdata_d;
   logic                   r_bypass, w_bypass_d;
   logic                   r_killed, w_killed_d;
   logic [SET_ASSOC-1:0]   r_hit_way, w_hit_way_d;

   logic [OFF_W-1:0]       w_off;
   logic [TAG_WIDTH-1:0]   w_cur_tag;
   logic                   w_uncached;
   logic [CL_WIDTH-1:0]    w_hit_line;
   logic [63:0]            w_hit_word;

   assign w_off       = r_index[3 +: OFF_W];
   // WAIT_TAG compares the tag arriving from the core; the replay state uses the saved one
   assign w_cur_tag   = (r_state == WAIT_TAG_SAVED) ? r_tag : req_port_i_address_tag;
   assign w_uncached  = ({{PAD_W{1'b0}}, w_cur_tag, r_index} < CACHE_START_ADDR);
   assign busy_o      = (r_state != IDLE);
   assign mshr_addr_o = {r_tag, r_index};

   always_comb begin
      w_hit_line = '0;
      w_hit_word = '0;
      for (int i = 0; i < SET_ASSOC; i++) begin
         if (hit_way_i[i]) w_hit_line = data_i[i*CL_WIDTH +: CL_WIDTH];
      end
      for (int w = 0; w < WORDS; w++) begin
         if (w_off == OFF_W'(w)) w_hit_word = w_hit_line[w*64 +: 64];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_index   <= '0;
         r_tag     <= '0;
         r_be      <= '0;
         r_size    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_bypass  <= 1'b0;
         r_killed  <= 1'b0;
         r_hit_way <= '0;
      end else begin
         r_state   <= w_state_d;
         r_index   <= w_index_d;
         r_tag     <= w_tag_d;
         r_be      <= w_be_d;
         r_size    <= w_size_d;
         r_we      <= w_we_d;
         r_wdata   <= w_wdata_d;
         r_bypass  <= w_bypass_d;
         r_killed  <= w_killed_d;
         r_hit_way <= w_hit_way_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_index_d   = r_index;
      w_tag_d     = r_tag;
      w_be_d      = r_be;
      w_size_d    = r_size;
      w_we_d      = r_we;
      w_wdata_d   = r_wdata;
      w_bypass_d  = r_bypass;
      w_killed_d  = r_killed;
      w_hit_way_d = r_hit_way;

      req_port_o_data_gnt    = 1'b0;
      req_port_o_data_rvalid = 1'b0;
      req_port_o_data_rdata  = '0;
      req_o                  = '0;
      addr_o                 = '0;
      tag_o                  = '0;
      data_o_tag             = '0;
      data_o_data            = '0;
      data_o_valid           = 1'b0;
      data_o_dirty           = 1'b0;
      we_o                   = 1'b0;
      be_o_tag               = '0;
      be_o_data              = '0;
      be_o_vldrty            = '0;
      miss_req_o_valid       = 1'b0;
      miss_req_o_addr        = '0;
      miss_req_o_be          = '0;
      miss_req_o_size        = '0;
      miss_req_o_we          = 1'b0;
      miss_req_o_wdata       = '0;
      miss_req_o_bypass      = 1'b0;

      case (r_state)
         IDLE: begin
            if (req_port_i_data_req && !flush_i) begin
               req_o  = '1;
               addr_o = req_port_i_address_index;
               if (gnt_i) begin
                  req_port_o_data_gnt = 1'b1;
                  w_index_d  = req_port_i_address_index;
                  w_be_d     = req_port_i_data_be;
                  w_size_d   = req_port_i_data_size;
                  w_we_d     = req_port_i_data_we;
                  w_wdata_d  = req_port_i_data_wdata;
                  w_bypass_d = bypass_i;
                  w_killed_d = 1'b0;
                  w_state_d  = bypass_i ? WAIT_TAG_BYPASSED : WAIT_TAG;
               end
            end
         end

         WAIT_TAG, WAIT_TAG_SAVED: begin
            tag_o = w_cur_tag;
            if (r_state == WAIT_TAG && req_port_i_kill_req) begin
               req_port_o_data_rvalid = 1'b1;
               w_state_d              = IDLE;
            end else if (r_state == WAIT_TAG_SAVED || req_port_i_tag_valid) begin
               w_tag_d = w_cur_tag;
               if (w_uncached) begin
                  w_bypass_d = 1'b1;
                  w_state_d  = WAIT_REFILL_GNT;
               end else if (|hit_way_i) begin
                  w_hit_way_d = hit_way_i;
                  if (r_we) begin
                     w_state_d = STORE_REQ;
                  end else begin
                     req_port_o_data_rvalid = !r_killed;
                     req_port_o_data_rdata  = w_hit_word;
                     w_state_d              = IDLE;
                  end
               end else if (mshr_addr_matches_i && active_serving_i) begin
                  w_state_d = WAIT_MSHR;
               end else begin
                  w_bypass_d = 1'b0;
                  w_state_d  = WAIT_REFILL_GNT;
               end
            end
         end

         WAIT_TAG_BYPASSED: begin
            if (req_port_i_kill_req) begin
               req_port_o_data_rvalid = 1'b1;
               w_state_d              = IDLE;
            end else if (req_port_i_tag_valid) begin
               w_tag_d    = req_port_i_address_tag;
               w_bypass_d = 1'b1;
               w_state_d  = WAIT_REFILL_GNT;
            end
         end

         STORE_REQ: begin
            addr_o = r_index;
            // Stall while the miss handler may be refilling this set
            if (!mshr_index_matches_i) begin
               req_o        = r_hit_way;
               we_o         = 1'b1;
               data_o_tag   = r_tag;
               data_o_valid = 1'b1;
               data_o_dirty = 1'b1;
               be_o_vldrty  = r_hit_way;
               for (int w = 0; w < WORDS; w++) begin
                  if (w_off == OFF_W'(w)) begin
                     data_o_data[w*64 +: 64] = r_wdata;
                     be_o_data[w*8 +: 8]     = r_be;
                  end
               end
               if (gnt_i) w_state_d = IDLE;
            end
         end

         WAIT_MSHR: begin
            if (!mshr_index_matches_i) begin
               req_o  = '1;
               addr_o = r_index;
               if (gnt_i) w_state_d = WAIT_TAG_SAVED;
            end
         end

         WAIT_REFILL_GNT: begin
            miss_req_o_valid  = 1'b1;
            miss_req_o_addr   = {{PAD_W{1'b0}}, r_tag, r_index[INDEX_WIDTH-1:3], 3'b000};
            miss_req_o_be     = r_be;
            miss_req_o_size   = r_size;
            miss_req_o_we     = r_we;
            miss_req_o_wdata  = r_wdata;
            miss_req_o_bypass = r_bypass;
            if (r_bypass) begin
               if (bypass_gnt_i) w_state_d = r_we ? IDLE : WAIT_REFILL_VALID;
            end else if (miss_gnt_i) begin
               w_state_d = r_we ? IDLE : WAIT_CRITICAL_WORD;
            end
         end

         WAIT_REFILL_VALID: begin
            if (bypass_valid_i) begin
               req_port_o_data_rvalid = !r_killed;
               req_port_o_data_rdata  = bypass_data_i;
               w_state_d              = IDLE;
            end
         end

         WAIT_CRITICAL_WORD: begin
            if (critical_word_valid_i) begin
               req_port_o_data_rvalid = !r_killed;
               req_port_o_data_rdata  = critical_word_i;
               w_state_d              = IDLE;
            end
         end

         default: w_state_d = IDLE;
      endcase

      // A late kill answers the core now; the outstanding refill still drains silently
      if (req_port_i_kill_req && !r_we && !r_killed &&
          (r_state inside {WAIT_MSHR, WAIT_REFILL_GNT, WAIT_REFILL_VALID, WAIT_CRITICAL_WORD})) begin
         req_port_o_data_rvalid = 1'b1;
         w_killed_d             = 1'b1;
      end
   end

endmodule

// File: tb/tb_std_cache_ctrl.sv
// Scoreboard bench for std_cache_ctrl: the bench plays core, arbiter, SRAM and miss handler.
module tb_std_cache_ctrl;

   localparam int SA = 4;
   localparam int IW = 12;
   localparam int TW = 44;
   localparam int CL = 128;

   logic              clk, rst_n;
   logic              flush, bypass;
   logic              busy;
   logic [IW-1:0]     p_index;
   logic [TW-1:0]     p_tag;
   logic [63:0]       p_wdata;
   logic              p_req, p_we, p_kill, p_tag_valid;
   logic [7:0]        p_be;
   logic [1:0]        p_size;
   logic              o_gnt, o_rvalid;
   logic [63:0]       o_rdata;
   logic [SA-1:0]     req_o;
   logic [IW-1:0]     addr_o;
   logic              gnt;
   logic [CL-1:0]     line_mem [SA];
   logic [SA*CL-1:0]  data_i;
   logic [TW-1:0]     tag_o, d_tag;
   logic [CL-1:0]     d_data;
   logic              d_valid, d_dirty, we_o;
   logic [SA-1:0]     be_tag, be_vldrty, hit_way;
   logic [CL/8-1:0]   be_data;
   logic              m_valid, m_we, m_bypass;
   logic [63:0]       m_addr, m_wdata;
   logic [7:0]        m_be;
   logic [1:0]        m_size;
   logic              miss_gnt, active_serving, cw_valid, byp_gnt, byp_valid;
   logic [63:0]       cw, byp_data;
   logic [TW+IW-1:0]  mshr_addr;
   logic              addr_match, index_match;

   assign data_i = {line_mem[3], line_mem[2], line_mem[1], line_mem[0]};

   std_cache_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bypass_i(bypass), .busy_o(busy),
      .req_port_i_address_index(p_index), .req_port_i_address_tag(p_tag),
      .req_port_i_data_wdata(p_wdata), .req_port_i_data_req(p_req), .req_port_i_data_we(p_we),
      .req_port_i_data_be(p_be), .req_port_i_data_size(p_size), .req_port_i_kill_req(p_kill),
      .req_port_i_tag_valid(p_tag_valid),
      .req_port_o_data_gnt(o_gnt), .req_port_o_data_rvalid(o_rvalid), .req_port_o_data_rdata(o_rdata),
      .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt), .data_i(data_i), .tag_o(tag_o),
      .data_o_tag(d_tag), .data_o_data(d_data), .data_o_valid(d_valid), .data_o_dirty(d_dirty),
      .we_o(we_o), .be_o_tag(be_tag), .be_o_data(be_data), .be_o_vldrty(be_vldrty),
      .hit_way_i(hit_way),
      .miss_req_o_valid(m_valid), .miss_req_o_addr(m_addr), .miss_req_o_be(m_be),
      .miss_req_o_size(m_size), .miss_req_o_we(m_we), .miss_req_o_wdata(m_wdata),
      .miss_req_o_bypass(m_bypass),
      .miss_gnt_i(miss_gnt), .active_serving_i(active_serving),
      .critical_word_i(cw), .critical_word_valid_i(cw_valid),
      .bypass_gnt_i(byp_gnt), .bypass_valid_i(byp_valid), .bypass_data_i(byp_data),
      .mshr_addr_o(mshr_addr), .mshr_addr_matches_i(addr_match), .mshr_index_matches_i(index_match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      bit          cmp;
   } exp_t;

   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_writes = 0;

   localparam logic [TW-1:0] T  = 44'h8_0010;
   localparam logic [TW-1:0] T2 = 44'h8_0123;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Response side of the scoreboard: every rvalid consumes one expectation
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && o_rvalid) begin
         if (sb_q.size() == 0) begin
            chk("rvalid_unexpected", o_rvalid, 1'b0);
         end else begin
            e = sb_q.pop_front();
            if (e.cmp) chk("rdata", o_rdata, e.data);
         end
      end
      if (rst_n && we_o && gnt) n_writes++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic exp_t mk(input logic [63:0] d, input bit c);
      exp_t e;
      e.data = d;
      e.cmp  = c;
      return e;
   endfunction

   function automatic logic [63:0] line_addr(input logic [TW-1:0] t, input logic [IW-1:0] i);
      return {8'h00, t, i} & ~64'h7;
   endfunction

   // Entered at posedge+1 with the controller idle; leaves it one cycle past the grant
   task automatic issue(input logic [IW-1:0] idx, input logic [63:0] wd,
                        input logic [7:0] be, input logic we);
      p_index = idx; p_wdata = wd; p_be = be; p_we = we; p_size = 2'd3;
      p_req = 1'b1; gnt = 1'b1;
      smp();
      chk("data_gnt", o_gnt, 1'b1);
      chk("lookup_req", req_o, {SA{1'b1}});
      chk("lookup_idx", addr_o, idx);
      tick();
      p_req = 1'b0; gnt = 1'b0;
   endtask

   task automatic tag_phase(input logic [TW-1:0] t, input logic [SA-1:0] hw);
      p_tag = t; p_tag_valid = 1'b1; hit_way = hw;
   endtask

   task automatic clr();
      p_tag_valid = 1'b0; hit_way = '0; p_kill = 1'b0; gnt = 1'b0;
      miss_gnt = 1'b0; cw_valid = 1'b0; byp_gnt = 1'b0; byp_valid = 1'b0;
      addr_match = 1'b0; active_serving = 1'b0; index_match = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; bypass = 1'b0;
      p_index = '0; p_tag = '0; p_wdata = '0; p_req = 1'b0; p_we = 1'b0;
      p_be = '0; p_size = '0; cw = '0; byp_data = '0;
      clr();
      line_mem[0] = {64'h0000_0000_0000_AAAA, 64'hBBBB_0000_0000_0001};
      line_mem[1] = {64'h0,                   64'h0000_0000_DEAD_BEEF};
      line_mem[2] = {64'h1111_2222_3333_4444, 64'h0};
      line_mem[3] = '0;
      tick(); tick();
      smp();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rvalid", o_rvalid, 1'b0);
      chk("rst_miss_valid", m_valid, 1'b0);
      chk("rst_req", req_o, '0);
      chk("rst_mshr_addr", mshr_addr, '0);
      chk("rst_we", we_o, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // load hit, word 0 of way 1
      sb_q.push_back(mk(64'hDEAD_BEEF, 1));
      issue(12'h010, '0, '0, 1'b0);
      tag_phase(T, 4'b0010);
      smp();
      chk("hit_tag_o", tag_o, T);
      chk("hit_busy", busy, 1'b1);
      tick(); clr();
      smp();
      chk("hit_idle", busy, 1'b0);
      tick();

      // load hit, word 1 of way 2
      sb_q.push_back(mk(64'h1111_2222_3333_4444, 1));
      issue(12'h018, '0, '0, 1'b0);
      tag_phase(T, 4'b0100);
      tick(); clr();

      // store hit at word 0
      issue(12'h010, 64'h1234, 8'hF0, 1'b1);
      tag_phase(T, 4'b0010);
      tick(); clr();
      gnt = 1'b1;
      smp();
      chk("st0_req", req_o, 4'b0010);
      chk("st0_data", d_data, 128'h1234);
      chk("st0_be", be_data, 16'h00F0);
      tick(); clr();
      smp();
      chk("st0_idle", busy, 1'b0);
      tick();

      // store hit at word 1, held off by an MSHR index match for 3 cycles
      issue(12'h018, 64'h1234, 8'h0F, 1'b1);
      tag_phase(T, 4'b0010);
      smp();
      chk("st_no_miss", m_valid, 1'b0);
      tick(); clr();
      for (int i = 0; i < 3; i++) begin
         index_match = 1'b1; gnt = 1'b1;
         smp();
         chk("st_hold_req", req_o, '0);
         chk("st_hold_we", we_o, 1'b0);
         tick();
      end
      index_match = 1'b0; gnt = 1'b1;
      smp();
      chk("st_req", req_o, 4'b0010);
      chk("st_we", we_o, 1'b1);
      chk("st_addr", addr_o, 12'h018);
      chk("st_data", d_data, {64'h1234, 64'h0});
      chk("st_be_data", be_data, 16'h0F00);
      chk("st_be_tag", be_tag, '0);
      chk("st_vldrty", be_vldrty, 4'b0010);
      chk("st_valid_dirty", {d_valid, d_dirty}, 2'b11);
      chk("st_tag", d_tag, T);
      tick(); clr();
      smp();
      chk("st_idle", busy, 1'b0);
      tick();

      // cacheable load miss
      sb_q.push_back(mk(64'hCAFE, 1));
      issue(12'h020, '0, '0, 1'b0);
      tag_phase(T, 4'b0000);
      tick(); clr();
      for (int i = 0; i < 2; i++) begin
         smp();
         chk("miss_valid", m_valid, 1'b1);
         chk("miss_addr", m_addr, line_addr(T, 12'h020));
         chk("miss_bypass", m_bypass, 1'b0);
         tick();
      end
      miss_gnt = 1'b1;
      smp();
      chk("miss_valid_gnt", m_valid, 1'b1);
      tick(); clr();
      smp();
      chk("cw_wait_no_miss", m_valid, 1'b0);
      chk("cw_wait_busy", busy, 1'b1);
      tick();
      cw = 64'hCAFE; cw_valid = 1'b1;
      tick(); clr();
      smp();
      chk("cw_idle", busy, 1'b0);
      tick();

      // bypass_i load
      sb_q.push_back(mk(64'h55, 1));
      bypass = 1'b1;
      issue(12'h030, '0, '0, 1'b0);
      bypass = 1'b0;
      tag_phase(T, 4'b0010);
      tick(); clr();
      byp_gnt = 1'b1;
      smp();
      chk("byp_valid", m_valid, 1'b1);
      chk("byp_flag", m_bypass, 1'b1);
      chk("byp_addr", m_addr, line_addr(T, 12'h030));
      tick(); clr();
      byp_data = 64'h55; byp_valid = 1'b1;
      tick(); clr();

      // address below the cacheable region bypasses even on a tag hit
      sb_q.push_back(mk(64'h77, 1));
      issue(12'h040, '0, '0, 1'b0);
      tag_phase(44'h1, 4'b0010);
      tick(); clr();
      smp();
      chk("unc_valid", m_valid, 1'b1);
      chk("unc_bypass", m_bypass, 1'b1);
      chk("unc_addr", m_addr, 64'h1040);
      byp_gnt = 1'b1;
      tick(); clr();
      byp_data = 64'h77; byp_valid = 1'b1;
      tick(); clr();

      // kill while waiting for the tag
      sb_q.push_back(mk(64'h0, 0));
      issue(12'h050, '0, '0, 1'b0);
      p_kill = 1'b1;
      smp();
      chk("kill_no_miss", m_valid, 1'b0);
      tick(); clr();
      smp();
      chk("kill_idle", busy, 1'b0);
      chk("kill_no_miss2", m_valid, 1'b0);
      tick();

      // miss on a line the MSHR is serving, replayed after the index clears
      sb_q.push_back(mk(64'hBBBB_0000_0000_0001, 1));
      issue(12'h010, '0, '0, 1'b0);
      tag_phase(T2, 4'b0000);
      addr_match = 1'b1; active_serving = 1'b1;
      tick(); clr();
      for (int i = 0; i < 2; i++) begin
         index_match = 1'b1; gnt = 1'b1;
         smp();
         chk("mshr_hold_req", req_o, '0);
         tick();
      end
      index_match = 1'b0; gnt = 1'b1;
      smp();
      chk("mshr_replay_req", req_o, {SA{1'b1}});
      chk("mshr_replay_idx", addr_o, 12'h010);
      chk("mshr_addr", mshr_addr, {T2, 12'h010});
      tick(); clr();
      hit_way = 4'b0001;
      smp();
      chk("saved_tag_o", tag_o, T2);
      tick(); clr();
      smp();
      chk("mshr_idle", busy, 1'b0);
      tick();

      // kill during the critical-word wait: one rvalid now, none at refill
      sb_q.push_back(mk(64'h0, 0));
      issue(12'h060, '0, '0, 1'b0);
      tag_phase(T, 4'b0000);
      tick(); clr();
      miss_gnt = 1'b1;
      tick(); clr();
      p_kill = 1'b1;
      tick(); clr();
      cw = 64'h9999; cw_valid = 1'b1;
      tick(); clr();
      smp();
      chk("late_kill_idle", busy, 1'b0);
      tick();

      // flush blocks new requests
      flush = 1'b1; p_req = 1'b1; gnt = 1'b1;
      smp();
      chk("flush_gnt", o_gnt, 1'b0);
      chk("flush_req", req_o, '0);
      tick();
      flush = 1'b0; p_req = 1'b0; clr();
      smp();
      chk("flush_idle", busy, 1'b0);
      tick();

      // cacheable store miss retires on miss grant
      issue(12'h070, 64'hABCD, 8'hFF, 1'b1);
      tag_phase(T, 4'b0000);
      tick(); clr();
      miss_gnt = 1'b1;
      smp();
      chk("stmiss_we", m_we, 1'b1);
      chk("stmiss_wdata", m_wdata, 64'hABCD);
      chk("stmiss_be", m_be, 8'hFF);
      tick(); clr();
      smp();
      chk("stmiss_idle", busy, 1'b0);
      tick();

      // asynchronous reset in the middle of a refill
      issue(12'h080, '0, '0, 1'b0);
      tag_phase(T, 4'b0000);
      tick(); clr();
      smp();
      chk("pre_rst_miss", m_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_miss", m_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_mshr", mshr_addr, '0);
      chk("mid_rst_req", req_o, '0);
      tick();
      rst_n = 1'b1;
      tick();
      smp();
      chk("post_rst_idle", busy, 1'b0);

      chk("sram_writes", n_writes, 2);
      chk("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
